div64x32: RTL and testbench

//  Sequential restoring divider: 64-bit dividend / 32-bit divisor -> 32-bit quotient (+ remainder).

---
 rtl/div64x32.sv | 116 +++++++++++
 tb/tb_div64x32.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div64x32.sv
// Sequential restoring divider, 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional remainder output enabled by defining DIV64X32_REM_EN.
module div64x32 #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   quotient,
   output logic           div_zero,
   output logic           overflow
`ifdef DIV64X32_REM_EN
   ,output logic [N-1:0]  remainder
`endif
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_DIVIDE,
      S_DONE
   } state_t;

   state_t        state, state_nx;
   logic [N-1:0]  dvd_hi, dvd_lo, dvs;
   logic [N-1:0]  r, r_nx, q;
   logic [N:0]    t;
   logic          ge, err, accept;
   logic [CW-1:0] cnt;

   // start is ignored while the done pulse is still showing
   assign accept = (state == S_IDLE) && start && !done;
   assign busy   = (state != S_IDLE);
   assign err    = (dvs == '0) || (dvd_hi >= dvs);

   // R only ever holds values below the divisor, so its top bit lives in T alone
   always_comb begin
      t    = {r, dvd_lo[N-1]};
      ge   = (t >= {1'b0, dvs});
      r_nx = ge ? N'(t - {1'b0, dvs}) : t[N-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = S_CHECK;
         S_CHECK:  state_nx = err ? S_DONE : S_DIVIDE;
         S_DIVIDE: if (cnt == '0) state_nx = S_DONE;
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd_hi   <= '0;
         dvd_lo   <= '0;
         dvs      <= '0;
         r        <= '0;
         q        <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         quotient <= '0;
         div_zero <= 1'b0;
         overflow <= 1'b0;
`ifdef DIV64X32_REM_EN
         remainder <= '0;
`endif
      end else begin
         done <= (state == S_DONE);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  dvd_hi   <= dividend[2*N-1:N];
                  dvd_lo   <= dividend[N-1:0];
                  dvs      <= divisor;
                  div_zero <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            S_CHECK: begin
               q   <= '0;
               cnt <= CW'(N - 1);
               r   <= err ? '0 : dvd_hi;
               if (dvs == '0) div_zero <= 1'b1;
               if (err)       overflow <= 1'b1;
            end
            S_DIVIDE: begin
               r      <= r_nx;
               q      <= {q[N-2:0], ge};
               dvd_lo <= {dvd_lo[N-2:0], 1'b0};
               cnt    <= cnt - 1'b1;
            end
            S_DONE: begin
               quotient <= q;
`ifdef DIV64X32_REM_EN
               remainder <= r;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div64x32.sv
// Self-checking bench for div64x32: directed cases plus random operands against a 64-bit reference.
// Builds with or without DIV64X32_REM_EN.
module tb_div64x32;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   dividend = '0;
   logic [31:0]   divisor = '0;
   logic          busy, done, div_zero, overflow;
   logic [31:0]   quotient;
`ifdef DIV64X32_REM_EN
   logic [31:0]   remainder;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   div64x32 #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .div_zero (div_zero),
      .overflow (overflow)
`ifdef DIV64X32_REM_EN
      ,.remainder(remainder)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [63:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz, output logic ov);
      dz = (b == 0);
      ov = (a[63:32] >= b);
      if (ov) begin
         q = 0;
         r = 0;
      end else begin
         q = 32'(a / {32'b0, b});
         r = 32'(a % {32'b0, b});
      end
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, 0);
      check({tag, ":quot"}, quotient, 0);
      check({tag, ":dz"}, div_zero, 0);
      check({tag, ":ov"}, overflow, 0);
`ifdef DIV64X32_REM_EN
      check({tag, ":rem"}, remainder, 0);
`endif
   endtask

   // pulse_at: edge index after which a stray start is injected; reset_at: edge index of an abort
   task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                         input int pulse_at, input int reset_at);
      logic [31:0] eq, er;
      logic        edz, eov;
      logic [63:0] prod, rem_obs;
      int          lat;
      bit          seen;
      model(a, b, eq, er, edz, eov);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, ":busy"}, busy, 1);
      lat  = 0;
      seen = 0;
      for (int i = 1; i <= 60 && !seen; i++) begin
         if (i == pulse_at) begin
            start    = 1'b1;
            dividend = {$urandom, $urandom};
            divisor  = $urandom;
         end
         @(posedge clk);
         #1;
         if (i == pulse_at) start = 1'b0;
         if (done) begin
            seen = 1;
            lat  = i;
         end
         if (i == reset_at) begin
            reset = 1'b0;
            #1 check_idle_outputs({tag, ":abort"});
            repeat (3) @(posedge clk);
            #1 check({tag, ":abort_nodone"}, done, 0);
            @(negedge clk);
            reset = 1'b1;
            return;
         end
      end
      check({tag, ":latency"}, lat, (edz || eov) ? 2 : N + 2);
      check({tag, ":quot"}, quotient, eq);
      check({tag, ":dz"}, div_zero, edz);
      check({tag, ":ov"}, overflow, eov);
      check({tag, ":busy_at_done"}, busy, 0);
      if (!(edz || eov)) begin
         prod = {32'b0, quotient} * {32'b0, b};
`ifdef DIV64X32_REM_EN
         check({tag, ":rem"}, remainder, er);
         rem_obs = {32'b0, remainder};
         check({tag, ":invariant"}, prod + rem_obs, a);
`else
         rem_obs = a - prod;
`endif
         check({tag, ":rem_lt_div"}, (rem_obs < {32'b0, b}) && (prod <= a), 1);
      end
`ifdef DIV64X32_REM_EN
      else check({tag, ":rem_err"}, remainder, 0);
`endif
      @(posedge clk);
      #1 check({tag, ":done_pulse"}, done, 0);
   endtask

   initial begin : main
      logic [31:0] b, hi;
      int          gap;
      bit          seen;

      repeat (3) @(posedge clk);
      #1 check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b1;

      run_op("c1", 64'd100, 32'd7, 0, 0);
      run_op("c2", 64'hFFFFFFFE_00000001, 32'hFFFFFFFF, 0, 0);
      run_op("c3", 64'h12345678_9ABCDEF0, 32'd0, 0, 0);
      run_op("c4", 64'h1_00000000, 32'd1, 0, 0);
      run_op("c5", 64'd100, 32'd7, 5, 0);
      run_op("c6", 64'd100, 32'd7, 0, 10);
      run_op("c6_rerun", 64'd100, 32'd7, 0, 0);
      run_op("maxq", 64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 0, 0);

      // held start: second op is accepted one cycle after the done pulse
      @(negedge clk);
      dividend = 64'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      seen = 0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(posedge clk);
         #1 if (done) seen = 1;
      end
      check("held:first_done", seen, 1);
      gap  = 0;
      seen = 0;
      for (int i = 1; i <= 80 && !seen; i++) begin
         @(posedge clk);
         #1 if (done) begin
            seen = 1;
            gap  = i;
         end
      end
      start = 1'b0;
      check("held:gap", gap, N + 4);
      check("held:quot", quotient, 14);
      repeat (3) @(posedge clk);

      for (int j = 0; j < 24; j++) begin
         b = $urandom;
         if (j % 4 == 0) b = $urandom_range(1, 255);
         if (b == 0) b = 1;
         hi = (j % 6 == 5) ? $urandom : ($urandom % b);
         run_op("rand", {hi, $urandom}, b, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
